// File: rtl/rv32m_muldiv_unit.sv
// rtl/rv32m_muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module rv32m_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                accept;
    logic                in_signed_a, in_signed_b, in_sa, in_sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                special;
    logic [XLEN-1:0]     special_val;
    logic [2*XLEN-1:0]   step_acc, step_a;
    logic [XLEN-1:0]     step_b;
    logic [XLEN:0]       rem;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem_fix, fix_val;

    assign accept = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

    // Operand signedness: MUL/MULH/DIV/REM sign both, MULHSU signs rs1 only.
    always_comb begin
        in_signed_a = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                      (op == 3'b100) || (op == 3'b110);
        in_signed_b = (op == 3'b000) || (op == 3'b001) ||
                      (op == 3'b100) || (op == 3'b110);
        in_sa = in_signed_a && a[XLEN-1];
        in_sb = in_signed_b && b[XLEN-1];
        mag_a = in_sa ? -a : a;
        mag_b = in_sb ? -b : b;
    end

    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (op[2]) begin
            if (b == '0) begin
                special     = 1'b1;
                special_val = op[1] ? a : '1;
            end else if (!op[0] && a == MIN_INT && b == '1) begin
                special     = 1'b1;
                special_val = op[1] ? '0 : MIN_INT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = special ? S_DONE : S_ITER;
                else        state_d = S_IDLE;
            end
            S_ITER: begin
                if (flush)                  state_d = S_IDLE;
                else if (cnt_q == CW'(1))   state_d = S_FIX;
            end
            S_FIX: begin
                state_d = flush ? S_IDLE : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE) || (state_q == S_DONE);
        busy  = (state_q == S_ITER) || (state_q == S_FIX);
        done  = (state_q == S_DONE);
    end

    assign result = result_q;

    // One iteration retires UNROLL bits; divide keeps the partial remainder in acc low bits.
    always_comb begin
        step_acc = acc_q;
        step_a   = opa_q;
        step_b   = opb_q;
        rem      = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                rem    = {step_acc[XLEN-1:0], step_b[XLEN-1]};
                step_b = {step_b[XLEN-2:0], 1'b0};
                if (rem >= {1'b0, step_a[XLEN-1:0]}) begin
                    rem       = rem - {1'b0, step_a[XLEN-1:0]};
                    step_b[0] = 1'b1;
                end
                step_acc = {{(XLEN-1){1'b0}}, rem};
            end else begin
                if (step_b[0]) step_acc = step_acc + step_a;
                step_a = step_a << 1;
                step_b = step_b >> 1;
            end
        end
    end

    always_comb begin
        prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo     = (sign_a_q ^ sign_b_q) ? -opb_q : opb_q;
        rem_fix = sign_a_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (op_q)
            3'b000:                 fix_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo;
            default:                fix_val = rem_fix;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (accept) begin
            op_d     = op;
            sign_a_d = in_sa;
            sign_b_d = in_sb;
            cnt_d    = CW'(N);
            acc_d    = '0;
            if (op[2]) begin
                opa_d = {{XLEN{1'b0}}, mag_b};
                opb_d = mag_a;
            end else begin
                opa_d = {{XLEN{1'b0}}, mag_a};
                opb_d = mag_b;
            end
            if (special) result_d = special_val;
        end else if (state_q == S_ITER && !flush) begin
            acc_d = step_acc;
            opa_d = step_a;
            opb_d = step_b;
            cnt_d = cnt_q - CW'(1);
        end else if (state_q == S_FIX && !flush) begin
            result_d = fix_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb/tb_rv32m_muldiv_unit.sv - directed vector bench for rv32m_muldiv_unit (UNROLL=1 and UNROLL=4)
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, sel;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        start1, start4;
    logic        ready1, busy1, done1, ready4, busy4, done4;
    logic [31:0] result1, result4;
    logic        ready_m, busy_m, done_m;
    logic [31:0] result_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start1   = start & ~sel;
    assign start4   = start & sel;
    assign ready_m  = sel ? ready4 : ready1;
    assign busy_m   = sel ? busy4 : busy1;
    assign done_m   = sel ? done4 : done1;
    assign result_m = sel ? result4 : result1;

    rv32m_muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op_i), .a(a_i), .b(b_i), .flush(flush),
        .ready(ready1), .busy(busy1), .done(done1), .result(result1)
    );

    rv32m_muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op_i), .a(a_i), .b(b_i), .flush(flush),
        .ready(ready4), .busy(busy4), .done(done4), .result(result4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%h exp=0x%h", nm, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 3'($urandom);
        lat = 1; busy_n = 0;
        while (!done_m && lat < 200) begin
            if (busy_m) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done_m) lat = -1;
        res = result_m;
    endtask

    task automatic watch_no_done(input string nm, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done_m) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat, busy_n, explat, cyc;

        rst = 1'b0; start = 1'b0; flush = 1'b0; sel = 1'b0;
        op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        chk("rst_result1", result1, 32'd0);
        chk("rst_ready4", 32'(ready4), 32'd1);
        chk("rst_result4", result4, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b101, 32'd7,        32'd2,        32'd3,        1'b0});
        vecs.push_back('{3'b111, 32'd7,        32'd2,        32'd1,        1'b0});
        vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
        vecs.push_back('{3'b111, 32'd5,        32'd0,        32'd5,        1'b1});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1});
        vecs.push_back('{3'b100, 32'h80000000, 32'd1,        32'h80000000, 1'b0});
        vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0});
        vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0});
        vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h10,       32'hF,        1'b0});
        vecs.push_back('{3'b011, 32'h10000,    32'h10000,    32'd1,        1'b0});
        vecs.push_back('{3'b000, 32'hFFFF,     32'hFFFF,     32'hFFFE0001, 1'b0});
        vecs.push_back('{3'b000, 32'd3,        32'd5,        32'd15,       1'b0});

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < vecs.size(); i++) begin
                run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_n);
                explat = vecs[i].special ? 1 : (s == 1 ? 10 : 34);
                chk($sformatf("u%0d_vec%0d_result", s, i), res, vecs[i].exp);
                chk($sformatf("u%0d_vec%0d_latency", s, i), 32'(lat), 32'(explat));
                chk($sformatf("u%0d_vec%0d_busycycles", s, i), 32'(busy_n),
                    32'(vecs[i].special ? 0 : explat - 1));
            end
        end
        sel = 1'b0;

        // done is a single-cycle pulse followed by IDLE
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, busy_n);
        chk("t1_result", res, 32'hFFFFFFEB);
        @(posedge clk); #1;
        chk("t1_done_drop", 32'(done_m), 32'd0);
        chk("t1_ready_idle", 32'(ready_m), 32'd1);

        // flush in cycle 10 of a DIV
        @(negedge clk);
        start = 1'b1; op_i = 3'b100; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 32'(ready_m), 32'd1);
        chk("flush_busy", 32'(busy_m), 32'd0);
        chk("flush_done", 32'(done_m), 32'd0);
        chk("flush_result_kept", result_m, 32'hFFFFFFEB);
        watch_no_done("flush_no_done", 40);

        // start and flush together: not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op_i = 3'b100; a_i = 32'd9; b_i = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", 32'(busy_m), 32'd0);
        chk("startflush_ready", 32'(ready_m), 32'd1);
        watch_no_done("startflush_no_done", 40);
        chk("startflush_result", result_m, 32'hFFFFFFEB);

        // start held while busy with changing operands
        @(negedge clk);
        start = 1'b1; op_i = 3'b000; a_i = 32'd3; b_i = 32'd5;
        @(posedge clk); #1;
        op_i = 3'b100; a_i = 32'd100; b_i = 32'd3;
        cyc = 1;
        while (!done_m && cyc < 200) begin
            if (cyc == 33) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("held_latency", 32'(cyc), 32'd34);
        chk("held_result", result_m, 32'd15);

        // back-to-back: start accepted in the DONE cycle
        run_op(3'b011, 32'h10000, 32'h10000, res, lat, busy_n);
        chk("b2b_first_result", res, 32'd1);
        chk("b2b_first_done", 32'(done_m), 32'd1);
        @(negedge clk);
        start = 1'b1; op_i = 3'b101; a_i = 32'd7; b_i = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!done_m && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_second_latency", 32'(cyc), 32'd34);
        chk("b2b_second_result", result_m, 32'd3);

        // asynchronous reset in cycle 5 of a MUL
        @(negedge clk);
        start = 1'b1; op_i = 3'b000; a_i = 32'd7; b_i = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_m), 32'd0);
        chk("arst_ready", 32'(ready_m), 32'd1);
        chk("arst_done", 32'(done_m), 32'd0);
        chk("arst_result", result_m, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        watch_no_done("arst_no_done", 40);
        chk("arst_ready_after", 32'(ready_m), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
